// File: rtl/controlador_refill_instrucoes.sv
// rtl/controlador_refill_instrucoes.sv - instruction cache line-refill engine
//
// On a cache miss this block fetches the 16-byte line as four sequential
// 32-bit words over a req/ack handshake. It then writes the assembled
// 128-bit line to the cache fill port as a one-cycle strobe.
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   miss_valid, miss_addr     miss request (level) and the PC that missed
//   mem_req, mem_addr         word read request and word-aligned address
//   mem_ack, mem_rdata        per-word completion pulse with read data
//   fill_we                   one-cycle line write strobe to the cache
//   fill_index, fill_tag      line index (PC[7:4]) and tag (PC[31:8])
//   fill_data                 line data, word k at [32k+31:32k]
//   refill_busy               high whenever the engine is not idle
//   refill_count              completed refills, saturating at 16'hFFFF

module controlador_refill_instrucoes (
    input  logic         clock,
    input  logic         reset,
    input  logic         miss_valid,
    input  logic [31:0]  miss_addr,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
    output logic         fill_we,
    output logic [3:0]   fill_index,
    output logic [23:0]  fill_tag,
    output logic [127:0] fill_data,
    output logic         refill_busy,
    output logic [15:0]  refill_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [27:0]       base_line;
    logic [1:0]        k;
    logic [3:0][31:0]  line_buf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_valid) state_next = REQ;
            REQ:     if (mem_ack && (k == 2'd3)) state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Base, index and tag are captured only on the IDLE->REQ transition, so
    // miss_addr activity while a refill is in flight has no effect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_line  <= '0;
            fill_index <= '0;
            fill_tag   <= '0;
            k          <= '0;
            line_buf   <= '0;
        end else begin
            if ((state == IDLE) && miss_valid) begin
                base_line  <= miss_addr[31:4];
                fill_index <= miss_addr[7:4];
                fill_tag   <= miss_addr[31:8];
                k          <= 2'd0;
            end
            if ((state == REQ) && mem_ack) begin
                line_buf[k] <= mem_rdata;
                k           <= k + 2'd1;
            end
        end
    end

    // The counter is only written on a refill so that it holds its value in
    // every other cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refill_count <= '0;
        end else if ((state == WRITE) && (refill_count != 16'hFFFF)) begin
            refill_count <= refill_count + 16'd1;
        end
    end

    // Outputs are decoded from the state register only. The word offset is
    // concatenated rather than added because base + 12 never carries out of
    // the line.
    assign mem_req     = (state == REQ);
    assign mem_addr    = mem_req ? {base_line, k, 2'b00} : 32'd0;
    assign fill_we     = (state == WRITE);
    assign refill_busy = (state != IDLE);
    assign fill_data   = line_buf;

endmodule
